// File: rtl/dct_2d_ctrl.sv
// ---------------------------------------------------------------------------
// dct_2d_ctrl
// Sequencer for a row/column 2D 8x8 DCT built around one shared dct_1d core
// and a 64-entry transpose buffer.
//
// Row pass   : pixels stream in raster order from the pixel bus into dct_1d;
//              row results are written into the transpose buffer.
// Column pass: the transpose buffer is read column-major back into dct_1d;
//              its results are the final 2D coefficients.
// Each pass is padded out to a multiple of 8 enabled cycles, so the dct_1d
// vector phase lines up from one pass (and one block) to the next.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst         in   asynchronous active-high reset
//   start       in   request one 8x8 block (only honoured in IDLE)
//   in_valid    in   pixel present on the pixel bus
//   in_ready    out  pixel accepted when in_valid && in_ready
//   out_ready   in   downstream accepts a 2D coefficient
//   dct_enb     out  dct_1d enable
//   dct_src     out  dct_1d input select (0 pixel bus, 1 transpose buffer)
//   tp_rd_addr  out  transpose-buffer read address (combinational read)
//   tp_wr_en    out  transpose-buffer write strobe
//   tp_wr_addr  out  transpose-buffer write address
//   out_valid   out  dct_out holds a final 2D coefficient
//   out_idx     out  coefficient index {v,u}, row-major
//   busy        out  high whenever not IDLE
//   done        out  one-cycle pulse at block completion
// ---------------------------------------------------------------------------
module dct_2d_ctrl #(
    parameter int DCT_LAT = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       dct_enb,
    output logic       dct_src,
    output logic [5:0] tp_rd_addr,
    output logic       tp_wr_en,
    output logic [5:0] tp_wr_addr,
    output logic       out_valid,
    output logic [5:0] out_idx,
    output logic       busy,
    output logic       done
);

    // Pass length: latency plus 64 samples, rounded up to whole vectors.
    localparam int         PASS_LEN = ((DCT_LAT + 64 + 7) / 8) * 8;
    localparam logic [6:0] K_LAST   = 7'(PASS_LEN - 1);
    localparam logic [6:0] WIN_LO   = 7'(DCT_LAT);
    localparam logic [6:0] WIN_HI   = 7'(DCT_LAT + 64);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_ROW_FLUSH,
        S_COL,
        S_COL_FLUSH,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] k_q, k_d;
    logic       done_q, done_d;

    // Result window of dct_1d within a pass, and the result index inside it.
    logic       in_win;
    logic [5:0] n;

    assign in_win = (k_q >= WIN_LO) && (k_q < WIN_HI);
    assign n      = 6'(k_q - WIN_LO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        done_d     = 1'b0;
        in_ready   = 1'b0;
        dct_enb    = 1'b0;
        dct_src    = 1'b0;
        tp_rd_addr = '0;
        tp_wr_en   = 1'b0;
        tp_wr_addr = '0;
        out_valid  = 1'b0;
        out_idx    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ROW;
                    k_d     = '0;
                end
            end

            S_ROW: begin
                in_ready = 1'b1;
                dct_enb  = in_valid;
                if (in_win) begin
                    tp_wr_addr = n;
                end
                tp_wr_en = dct_enb && in_win;
                if (dct_enb) begin
                    k_d = k_q + 7'd1;
                    if (k_q == 7'd63) begin
                        state_d = S_ROW_FLUSH;
                    end
                end
            end

            S_ROW_FLUSH: begin
                dct_enb = 1'b1;
                if (in_win) begin
                    tp_wr_addr = n;
                end
                tp_wr_en = in_win;
                if (k_q == K_LAST) begin
                    state_d = S_COL;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 7'd1;
                end
            end

            S_COL: begin
                dct_src = 1'b1;
                dct_enb = out_ready;
                // Column-major read: swapping the index halves transposes.
                if (k_q < 7'd64) begin
                    tp_rd_addr = {k_q[2:0], k_q[5:3]};
                end
                if (in_win) begin
                    out_idx = {n[2:0], n[5:3]};
                end
                out_valid = dct_enb && in_win;
                if (dct_enb) begin
                    k_d = k_q + 7'd1;
                    if (k_q == 7'd63) begin
                        state_d = S_COL_FLUSH;
                    end
                end
            end

            S_COL_FLUSH: begin
                dct_src = 1'b1;
                dct_enb = out_ready;
                if (in_win) begin
                    out_idx = {n[2:0], n[5:3]};
                end
                out_valid = dct_enb && in_win;
                if (dct_enb) begin
                    if (k_q == K_LAST) begin
                        state_d = S_DONE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 7'd1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // done is registered and therefore high exactly while in DONE.
        done_d = (state_d == S_DONE);
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: doc/dct_2d_ctrl.md
DCT_2D_CTRL -- requirements
Module: dct_2d_ctrl

Interface
REQ-001 SHALL have parameter DCT_LAT, default 9: dct_1d enable cycles from sample 0 of a vector to coefficient 0 on dct_out; legal range 1..56.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request to process one 8x8 block.
REQ-005 SHALL have port in_valid, input, 1: pixel present on the shared pixel bus.
REQ-006 SHALL have port in_ready, output, 1: pixel accepted when in_valid && in_ready.
REQ-007 SHALL have port out_ready, input, 1: downstream accepts a 2D coefficient.
REQ-008 SHALL have port dct_enb, output, 1: enable to dct_1d.
REQ-009 SHALL have port dct_src, output, 1: dct_1d input mux select; 0 = pixel bus, 1 = transpose-buffer read data.
REQ-010 SHALL have port tp_rd_addr, output, 6: transpose-buffer read address, combinational read.
REQ-011 SHALL have port tp_wr_en, output, 1: transpose-buffer write strobe for the current dct_out.
REQ-012 SHALL have port tp_wr_addr, output, 6: transpose-buffer write address.
REQ-013 SHALL have port out_valid, output, 1: dct_out holds a final 2D coefficient.
REQ-014 SHALL have port out_idx, output, 6: coefficient index {v[2:0],u[2:0]}, row-major.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at block completion.

Function
REQ-017 SHALL implement states IDLE, ROW, ROW_FLUSH, COL, COL_FLUSH, DONE.
REQ-018 SHALL count dct_enb cycles per pass in k (7 bits), cleared on entry to ROW and COL; pass length P = DCT_LAT+64 rounded up to a multiple of 8 (80 by default).
REQ-019 SHALL move IDLE->ROW on start; start SHALL be ignored in all other states.
REQ-020 SHALL, in ROW, drive in_ready=1, dct_src=0, and dct_enb=in_valid; each accepted pixel is feed index m=k (raster order); SHALL move ROW->ROW_FLUSH when pixel 63 is accepted.
REQ-021 SHALL, in ROW_FLUSH, drive in_ready=0, dct_enb=1, and move to COL when k=P-1 with dct_enb high.
REQ-022 SHALL, in ROW/ROW_FLUSH, assert tp_wr_en when dct_enb && DCT_LAT<=k<DCT_LAT+64, with tp_wr_addr=k-DCT_LAT.
REQ-023 SHALL, in COL/COL_FLUSH, drive dct_src=1 and dct_enb=out_ready; an out_ready=0 cycle freezes k and all outputs except out_valid.
REQ-024 SHALL, in COL with k<64, drive tp_rd_addr={k[2:0],k[5:3]} (column-major read); SHALL move COL->COL_FLUSH after the enabled cycle with k=63.
REQ-025 SHALL, in COL/COL_FLUSH, assert out_valid when dct_enb && DCT_LAT<=k<DCT_LAT+64; with n=k-DCT_LAT, out_idx={n[2:0],n[5:3]}.
REQ-026 SHALL move COL_FLUSH->DONE at k=P-1 with dct_enb high; DONE SHALL assert done for one cycle and then move to IDLE.
REQ-027 SHALL drive tp_wr_en=0 outside ROW/ROW_FLUSH, out_valid=0 outside COL/COL_FLUSH, and in_ready=0 outside ROW.
REQ-028 SHALL leave every pass at a multiple of 8 enabled cycles so that the dct_1d vector phase is preserved across passes and blocks.
REQ-029 SHALL register the state, k, and done; all other outputs are decoded combinationally from state, k, in_valid, and out_ready.

Reset
REQ-030 SHALL, while rst=1, force IDLE, k=0, and every output to 0 (tp_rd_addr=0, tp_wr_addr=0, out_idx=0), regardless of the clock.
REQ-031 SHALL abandon a block on reset mid-operation with no done pulse; dct_1d SHALL share rst so its phase restarts aligned.

Verification
REQ-032 Reset then start with in_valid held 1 -> in_ready high for exactly 64 cycles; tp_wr_en first at k=9 with addr 0 and last at addr 63; ROW lasts 80 enabled cycles.
REQ-033 Column pass with out_ready=1 -> tp_rd_addr sequence 0,8,16,...,56,1,9,...,63; 64 out_valid pulses with out_idx 0,8,16,...,56,1,...; done once, 160 cycles after start.
REQ-034 in_valid toggled 1010... during ROW -> dct_enb mirrors in_valid, k advances only on accepts, written addresses unchanged versus REQ-032.
REQ-035 out_ready low for 5 cycles mid-COL -> k, tp_rd_addr, and out_idx frozen, out_valid low, and the total out_valid count still 64.
REQ-036 rst asserted at k=30 in COL -> all outputs 0 immediately; a following start produces a correct full block.
REQ-037 start pulsed during ROW and in the DONE cycle -> ignored, with exactly one block processed.
